// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcodes, and the ALUOp / ALUSrcB / PCSource select codes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_outputs.sv
// Combinational state-to-strobe decoder; Reset forces every strobe low so no
// PC, IR, memory or register write can happen while the unit is held.
module multicycle_control_outputs
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       reset_i,
    output logic       pcWrite_o,
    output logic       pcWriteCond_o,
    output logic       iorD_o,
    output logic       memRead_o,
    output logic       memWrite_o,
    output logic       memtoReg_o,
    output logic       irWrite_o,
    output logic [1:0] pcSource_o,
    output logic [1:0] aluOp_o,
    output logic       aluSrcA_o,
    output logic [1:0] aluSrcB_o,
    output logic       regWrite_o,
    output logic       regDst_o
);

    always_comb begin
        pcWrite_o     = 1'b0;
        pcWriteCond_o = 1'b0;
        iorD_o        = 1'b0;
        memRead_o     = 1'b0;
        memWrite_o    = 1'b0;
        memtoReg_o    = 1'b0;
        irWrite_o     = 1'b0;
        pcSource_o    = PCSRC_ALU;
        aluOp_o       = ALUOP_ADD;
        aluSrcA_o     = 1'b0;
        aluSrcB_o     = SRCB_REGB;
        regWrite_o    = 1'b0;
        regDst_o      = 1'b0;
        if (!reset_i) begin
            case (state_i)
                S_FETCH: begin
                    memRead_o  = 1'b1;
                    irWrite_o  = 1'b1;
                    aluSrcB_o  = SRCB_FOUR;
                    aluOp_o    = ALUOP_ADD;
                    pcWrite_o  = 1'b1;
                    pcSource_o = PCSRC_ALU;
                end
                S_DECODE: begin
                    aluSrcB_o = SRCB_IMMSH;
                    aluOp_o   = ALUOP_ADD;
                end
                S_MEMADDR, S_ADDIEX: begin
                    aluSrcA_o = 1'b1;
                    aluSrcB_o = SRCB_IMM;
                    aluOp_o   = ALUOP_ADD;
                end
                S_MEMRD: begin
                    memRead_o = 1'b1;
                    iorD_o    = 1'b1;
                end
                S_MEMWB: begin
                    regWrite_o = 1'b1;
                    memtoReg_o = 1'b1;
                end
                S_MEMWR: begin
                    memWrite_o = 1'b1;
                    iorD_o     = 1'b1;
                end
                S_EXEC: begin
                    aluSrcA_o = 1'b1;
                    aluSrcB_o = SRCB_REGB;
                    aluOp_o   = ALUOP_FUNC;
                end
                S_RWB: begin
                    regWrite_o = 1'b1;
                    regDst_o   = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA_o     = 1'b1;
                    aluSrcB_o     = SRCB_REGB;
                    aluOp_o       = ALUOP_SUB;
                    pcWriteCond_o = 1'b1;
                    pcSource_o    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    pcWrite_o  = 1'b1;
                    pcSource_o = PCSRC_JUMP;
                end
                S_ADDIWB: begin
                    regWrite_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each
// instruction through its states and flags opcodes it cannot execute.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Op is only looked at in DECODE and MEMADDR; every other state has a fixed successor.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXEC:    state_d = S_RWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    assign State     = state_q;
    assign IllegalOp = illegal_q;

    multicycle_control_outputs u_outputs (
        .state_i       (state_q),
        .reset_i       (Reset),
        .pcWrite_o     (PCWrite),
        .pcWriteCond_o (PCWriteCond),
        .iorD_o        (IorD),
        .memRead_o     (MemRead),
        .memWrite_o    (MemWrite),
        .memtoReg_o    (MemtoReg),
        .irWrite_o     (IRWrite),
        .pcSource_o    (PCSource),
        .aluOp_o       (ALUOp),
        .aluSrcA_o     (ALUSrcA),
        .aluSrcB_o     (ALUSrcB),
        .regWrite_o    (RegWrite),
        .regDst_o      (RegDst)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction paths plus
// randomized instruction streams against a per-instruction path model.
module tb_multicycle_control;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [5:0] Op;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, IllegalOp;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;
    logic illegalExp = 1'b0;

    typedef struct packed {
        logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memtoReg, irWrite;
        logic [1:0] pcSource, aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       regWrite, regDst;
    } strobe_t;

    multicycle_control dut (
        .Clk(Clk), .Reset(Reset), .Op(Op),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 Clk = ~Clk;

    // Instruction-level view: how many cycles each opcode takes, and which state it is in at cycle k.
    function automatic int pathLen(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int pathState(input logic [5:0] op, input int k);
        if (k < 2) return k;
        case (op)
            6'b100011: return k + 0;
            6'b101011: return (k == 2) ? 2 : 5;
            6'b000000: return (k == 2) ? 6 : 7;
            6'b000100: return 8;
            6'b000010: return 9;
            6'b001000: return (k == 2) ? 10 : 11;
            default:   return 0;
        endcase
    endfunction

    function automatic strobe_t expStrobes(input int s, input logic rst);
        strobe_t t;
        t = '0;
        if (rst) return t;
        case (s)
            0:  begin t.memRead = 1; t.irWrite = 1; t.aluSrcB = 2'b01; t.pcWrite = 1; end
            1:  t.aluSrcB = 2'b11;
            2:  begin t.aluSrcA = 1; t.aluSrcB = 2'b10; end
            3:  begin t.memRead = 1; t.iorD = 1; end
            4:  begin t.regWrite = 1; t.memtoReg = 1; end
            5:  begin t.memWrite = 1; t.iorD = 1; end
            6:  begin t.aluSrcA = 1; t.aluOp = 2'b10; end
            7:  begin t.regWrite = 1; t.regDst = 1; end
            8:  begin t.aluSrcA = 1; t.aluOp = 2'b01; t.pcWriteCond = 1; t.pcSource = 2'b01; end
            9:  begin t.pcWrite = 1; t.pcSource = 2'b10; end
            10: begin t.aluSrcA = 1; t.aluSrcB = 2'b10; end
            11: t.regWrite = 1;
            default: ;
        endcase
        return t;
    endfunction

    function automatic strobe_t observed();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        Op    = 6'b100011;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            checks++;
            if (State !== 4'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", State); end
            checks++;
            if (observed() !== expStrobes(0, 1'b1)) begin
                errors++; $display("[TB] FAIL reset_strobes got %h want %h", observed(), expStrobes(0, 1'b1));
            end
            checks++;
            if (IllegalOp !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got %b want 0", IllegalOp); end
        end
        Reset = 1'b0;
        illegalExp = 1'b0;
    endtask

    task automatic test_path(input string name, input logic [5:0] op);
        int s;
        for (int k = 0; k < pathLen(op); k++) begin
            s  = pathState(op, k);
            Op = op;
            #1;
            checks++;
            if (State !== 4'(s)) begin errors++; $display("[TB] FAIL %s_state k=%0d got %0d want %0d", name, k, State, s); end
            checks++;
            if (observed() !== expStrobes(s, 1'b0)) begin
                errors++; $display("[TB] FAIL %s_strobes k=%0d got %h want %h", name, k, observed(), expStrobes(s, 1'b0));
            end
            checks++;
            if (IllegalOp !== illegalExp) begin errors++; $display("[TB] FAIL %s_illegal k=%0d got %b want %b", name, k, IllegalOp, illegalExp); end
            @(posedge Clk); #1;
            if (s == 1 && pathLen(op) == 2) illegalExp = 1'b1;
        end
    endtask

    task automatic test_lw();          test_path("lw", 6'b100011);    endtask
    task automatic test_rtype();       test_path("rtype", 6'b000000); endtask
    task automatic test_branch_jump(); test_path("beq", 6'b000100); test_path("j", 6'b000010); endtask

    task automatic test_sw_op_toggle();
        int s;
        int memWrites = 0;
        for (int k = 0; k < 4; k++) begin
            s  = pathState(6'b101011, k);
            Op = (s == 5) ? 6'b100011 : 6'b101011;
            #1;
            memWrites += int'(MemWrite);
            checks++;
            if (State !== 4'(s)) begin errors++; $display("[TB] FAIL sw_state k=%0d got %0d want %0d", k, State, s); end
            checks++;
            if (observed() !== expStrobes(s, 1'b0)) begin
                errors++; $display("[TB] FAIL sw_strobes k=%0d got %h want %h", k, observed(), expStrobes(s, 1'b0));
            end
            @(posedge Clk); #1;
        end
        checks++;
        if (memWrites != 1) begin errors++; $display("[TB] FAIL sw_memwrite_count got %0d want 1", memWrites); end
        checks++;
        if (State !== 4'd0) begin errors++; $display("[TB] FAIL sw_return got %0d want 0", State); end
    endtask

    task automatic test_illegal_then_addi();
        test_path("illegal", 6'b111111);
        checks++;
        if (IllegalOp !== 1'b1) begin errors++; $display("[TB] FAIL illegal_sticky got %b want 1", IllegalOp); end
        test_path("addi", 6'b001000);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        illegalExp = 1'b0;
        checks++;
        if (IllegalOp !== 1'b0) begin errors++; $display("[TB] FAIL illegal_clear got %b want 0", IllegalOp); end
    endtask

    task automatic test_reset_abort();
        int regWrites = 0;
        for (int k = 0; k < 3; k++) begin
            Op = 6'b100011;
            @(posedge Clk); #1;
        end
        Reset = 1'b1;
        #1;
        regWrites += int'(RegWrite);
        checks++;
        if (State !== 4'd3) begin errors++; $display("[TB] FAIL abort_state got %0d want 3", State); end
        checks++;
        if (observed() !== expStrobes(3, 1'b1)) begin
            errors++; $display("[TB] FAIL abort_strobes got %h want %h", observed(), expStrobes(3, 1'b1));
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        #1;
        regWrites += int'(RegWrite);
        checks++;
        if (State !== 4'd0) begin errors++; $display("[TB] FAIL abort_next got %0d want 0", State); end
        checks++;
        if (regWrites != 0) begin errors++; $display("[TB] FAIL abort_regwrite got %0d want 0", regWrites); end
    endtask

    task automatic test_random();
        logic [5:0] legalOps [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
        logic [5:0] op;
        int s, len, abortAt;
        for (int n = 0; n < 60; n++) begin
            op      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legalOps[$urandom_range(0, 5)];
            len     = pathLen(op);
            abortAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int k = 0; k < len; k++) begin
                s  = pathState(op, k);
                Op = (s == 1 || s == 2) ? op : 6'($urandom);
                Reset = (k == abortAt);
                #1;
                checks++;
                if (State !== 4'(s)) begin errors++; $display("[TB] FAIL rand_state n=%0d op=%b k=%0d got %0d want %0d", n, op, k, State, s); end
                checks++;
                if (observed() !== expStrobes(s, Reset)) begin
                    errors++; $display("[TB] FAIL rand_strobes n=%0d op=%b k=%0d got %h want %h", n, op, k, observed(), expStrobes(s, Reset));
                end
                checks++;
                if (IllegalOp !== illegalExp) begin errors++; $display("[TB] FAIL rand_illegal n=%0d got %b want %b", n, IllegalOp, illegalExp); end
                @(posedge Clk); #1;
                if (Reset) begin
                    Reset = 1'b0;
                    illegalExp = 1'b0;
                    break;
                end
                if (s == 1 && len == 2) illegalExp = 1'b1;
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch_jump();
        test_sw_op_toggle();
        test_illegal_then_addi();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
